reg_bank: RTL

Register bank that sits directly downstream of the SPI slave. It decodes the 7-bit address / 8-bit data / write-strobe bus into a SID-compatible register map held in shadow registers. The shadow registers are committed atomically to the voice and filter datapath on each sample tick. Read-back, including snapshots of the read-only OSC3/ENV3 registers, is returned to the SPI slave one cycle after the address is presented. Gate edge detection produces per-voice key-on/key-off pulses for the envelope generators.

---
 rtl/tt6581_pkg.sv | 46 ++++
 rtl/voice_regs.sv | 76 +++++++
 rtl/reg_bank.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/tt6581_pkg.sv
// tt6581_pkg: shared address map, widths and voice register payload for the
// SID-compatible register bank.
// No ports; imported by voice_regs and reg_bank.
package tt6581_pkg;

  localparam int unsigned NUM_VOICES = 3;
  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned OFF_W      = 3;
  localparam int unsigned FREQ_W     = 16;
  localparam int unsigned PW_W       = 12;
  localparam int unsigned FC_W       = 11;

  // Voice base addresses
  localparam logic [ADDR_W-1:0] VOICE_BASE_0 = 7'h00;
  localparam logic [ADDR_W-1:0] VOICE_BASE_1 = 7'h07;
  localparam logic [ADDR_W-1:0] VOICE_BASE_2 = 7'h0E;

  // Per-voice register offsets
  localparam logic [OFF_W-1:0] OFF_FREQ_LO = 3'd0;
  localparam logic [OFF_W-1:0] OFF_FREQ_HI = 3'd1;
  localparam logic [OFF_W-1:0] OFF_PW_LO   = 3'd2;
  localparam logic [OFF_W-1:0] OFF_PW_HI   = 3'd3;
  localparam logic [OFF_W-1:0] OFF_CTRL    = 3'd4;
  localparam logic [OFF_W-1:0] OFF_AD      = 3'd5;
  localparam logic [OFF_W-1:0] OFF_SR      = 3'd6;

  // Global registers
  localparam logic [ADDR_W-1:0] ADDR_FC_LO    = 7'h15;
  localparam logic [ADDR_W-1:0] ADDR_FC_HI    = 7'h16;
  localparam logic [ADDR_W-1:0] ADDR_RES_FILT = 7'h17;
  localparam logic [ADDR_W-1:0] ADDR_MODE_VOL = 7'h18;
  localparam logic [ADDR_W-1:0] ADDR_POTX     = 7'h19;
  localparam logic [ADDR_W-1:0] ADDR_POTY     = 7'h1A;
  localparam logic [ADDR_W-1:0] ADDR_OSC3     = 7'h1B;
  localparam logic [ADDR_W-1:0] ADDR_ENV3     = 7'h1C;

  typedef struct packed {
    logic [FREQ_W-1:0] freq;
    logic [PW_W-1:0]   pw;
    logic [DATA_W-1:0] ctrl;
    logic [DATA_W-1:0] ad;
    logic [DATA_W-1:0] sr;
  } voice_regs_t;

endpackage

// File: rtl/voice_regs.sv
// voice_regs: shadow/active register pair for one voice plus gate edge pulses.
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   sel                register offset within the voice (0..6)
//   we, wdata          write strobe (already qualified for this voice), data
//   tick               sample tick; commits shadow to active
//   rdata_c            combinational read byte of the shadow at sel
//   active             committed register set
//   gate_on, gate_off  one-cycle pulses on committed gate rising/falling edge
module voice_regs
  import tt6581_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [OFF_W-1:0]  sel,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              tick,
  output logic [DATA_W-1:0] rdata_c,
  output voice_regs_t       active,
  output logic              gate_on,
  output logic              gate_off
);

  voice_regs_t shadow;

  // Shadow write; PW_HI keeps only its low nibble
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow <= '0;
    end else if (we) begin
      case (sel)
        OFF_FREQ_LO: shadow.freq[7:0]  <= wdata;
        OFF_FREQ_HI: shadow.freq[15:8] <= wdata;
        OFF_PW_LO:   shadow.pw[7:0]    <= wdata;
        OFF_PW_HI:   shadow.pw[11:8]   <= wdata[3:0];
        OFF_CTRL:    shadow.ctrl       <= wdata;
        OFF_AD:      shadow.ad         <= wdata;
        OFF_SR:      shadow.sr         <= wdata;
        default:     ;
      endcase
    end
  end

  // Commit; gate edge compares incoming shadow gate against committed gate
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active   <= '0;
      gate_on  <= 1'b0;
      gate_off <= 1'b0;
    end else if (tick) begin
      active   <= shadow;
      gate_on  <= shadow.ctrl[0] & ~active.ctrl[0];
      gate_off <= ~shadow.ctrl[0] & active.ctrl[0];
    end else begin
      gate_on  <= 1'b0;
      gate_off <= 1'b0;
    end
  end

  // Read mux over the shadow
  always_comb begin
    rdata_c = '0;
    case (sel)
      OFF_FREQ_LO: rdata_c = shadow.freq[7:0];
      OFF_FREQ_HI: rdata_c = shadow.freq[15:8];
      OFF_PW_LO:   rdata_c = shadow.pw[7:0];
      OFF_PW_HI:   rdata_c = {4'h0, shadow.pw[11:8]};
      OFF_CTRL:    rdata_c = shadow.ctrl;
      OFF_AD:      rdata_c = shadow.ad;
      OFF_SR:      rdata_c = shadow.sr;
      default:     rdata_c = '0;
    endcase
  end

endmodule

// File: rtl/reg_bank.sv
// reg_bank: SID-compatible register bank behind the SPI slave. Decodes the
// address/data/strobe bus into shadow registers, commits them to the datapath
// on each sample tick, snapshots OSC3/ENV3 and returns registered read data.
// Ports:
//   clk_i, rst_ni                    clock, async active-low reset
//   reg_addr_i, reg_wdata_i, reg_we_i register bus from the SPI slave
//   reg_rdata_o                      read data, one cycle after address
//   sample_tick_i                    commit strobe
//   osc3_i, env3_i                   live voice-3 values to snapshot
//   freq_o/pw_o/ctrl_o/ad_o/sr_o     committed per-voice registers
//   fc_o, res_filt_o, mode_vol_o     committed filter/volume registers
//   gate_on_o, gate_off_o            per-voice key-on/key-off pulses
module reg_bank
  import tt6581_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_W-1:0]     reg_addr_i,
  input  logic [DATA_W-1:0]     reg_wdata_i,
  input  logic                  reg_we_i,
  output logic [DATA_W-1:0]     reg_rdata_o,
  input  logic                  sample_tick_i,
  input  logic [DATA_W-1:0]     osc3_i,
  input  logic [DATA_W-1:0]     env3_i,
  output logic [FREQ_W-1:0]     freq_o [NUM_VOICES],
  output logic [PW_W-1:0]       pw_o   [NUM_VOICES],
  output logic [DATA_W-1:0]     ctrl_o [NUM_VOICES],
  output logic [DATA_W-1:0]     ad_o   [NUM_VOICES],
  output logic [DATA_W-1:0]     sr_o   [NUM_VOICES],
  output logic [FC_W-1:0]       fc_o,
  output logic [DATA_W-1:0]     res_filt_o,
  output logic [DATA_W-1:0]     mode_vol_o,
  output logic [NUM_VOICES-1:0] gate_on_o,
  output logic [NUM_VOICES-1:0] gate_off_o
);

  logic [NUM_VOICES-1:0] voice_hit_c;
  logic [OFF_W-1:0]      voice_off_c;
  logic [DATA_W-1:0]     voice_rdata_c [NUM_VOICES];
  voice_regs_t           voice_active  [NUM_VOICES];
  logic [DATA_W-1:0]     rdata_c;

  logic [FC_W-1:0]   fc_sh;
  logic [DATA_W-1:0] res_filt_sh;
  logic [DATA_W-1:0] mode_vol_sh;
  logic [DATA_W-1:0] osc3_snap;
  logic [DATA_W-1:0] env3_snap;

  // Voice address decode: which voice, and offset within it
  always_comb begin
    voice_hit_c = '0;
    voice_off_c = '0;
    if (reg_addr_i < VOICE_BASE_1) begin
      voice_hit_c[0] = 1'b1;
      voice_off_c    = OFF_W'(reg_addr_i - VOICE_BASE_0);
    end else if (reg_addr_i < VOICE_BASE_2) begin
      voice_hit_c[1] = 1'b1;
      voice_off_c    = OFF_W'(reg_addr_i - VOICE_BASE_1);
    end else if (reg_addr_i < ADDR_FC_LO) begin
      voice_hit_c[2] = 1'b1;
      voice_off_c    = OFF_W'(reg_addr_i - VOICE_BASE_2);
    end
  end

  for (genvar v = 0; v < int'(NUM_VOICES); v++) begin : g_voice
    voice_regs u_voice_regs (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .sel      (voice_off_c),
      .we       (reg_we_i & voice_hit_c[v]),
      .wdata    (reg_wdata_i),
      .tick     (sample_tick_i),
      .rdata_c  (voice_rdata_c[v]),
      .active   (voice_active[v]),
      .gate_on  (gate_on_o[v]),
      .gate_off (gate_off_o[v])
    );

    assign freq_o[v] = voice_active[v].freq;
    assign pw_o[v]   = voice_active[v].pw;
    assign ctrl_o[v] = voice_active[v].ctrl;
    assign ad_o[v]   = voice_active[v].ad;
    assign sr_o[v]   = voice_active[v].sr;
  end

  // Filter/volume shadow; FC_LO keeps only bits 2:0
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fc_sh       <= '0;
      res_filt_sh <= '0;
      mode_vol_sh <= '0;
    end else if (reg_we_i) begin
      case (reg_addr_i)
        ADDR_FC_LO:    fc_sh[2:0]  <= reg_wdata_i[2:0];
        ADDR_FC_HI:    fc_sh[10:3] <= reg_wdata_i;
        ADDR_RES_FILT: res_filt_sh <= reg_wdata_i;
        ADDR_MODE_VOL: mode_vol_sh <= reg_wdata_i;
        default:       ;
      endcase
    end
  end

  // Filter/volume commit and OSC3/ENV3 snapshot on the sample tick
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fc_o       <= '0;
      res_filt_o <= '0;
      mode_vol_o <= '0;
      osc3_snap  <= '0;
      env3_snap  <= '0;
    end else if (sample_tick_i) begin
      fc_o       <= fc_sh;
      res_filt_o <= res_filt_sh;
      mode_vol_o <= mode_vol_sh;
      osc3_snap  <= osc3_i;
      env3_snap  <= env3_i;
    end
  end

  // Read mux; POTX/POTY and unmapped addresses fall through to zero
  always_comb begin
    rdata_c = '0;
    for (int v = 0; v < int'(NUM_VOICES); v++) begin
      if (voice_hit_c[v]) rdata_c = voice_rdata_c[v];
    end
    case (reg_addr_i)
      ADDR_FC_LO:    rdata_c = {5'h00, fc_sh[2:0]};
      ADDR_FC_HI:    rdata_c = fc_sh[10:3];
      ADDR_RES_FILT: rdata_c = res_filt_sh;
      ADDR_MODE_VOL: rdata_c = mode_vol_sh;
      ADDR_OSC3:     rdata_c = osc3_snap;
      ADDR_ENV3:     rdata_c = env3_snap;
      default:       ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) reg_rdata_o <= '0;
    else         reg_rdata_o <= rdata_c;
  end

endmodule
